addr_reg_bank: RTL
==================

// Module: addr_reg_bank
// PURPOSE
//   Bank of N_CH independent address registers, the parametrised successor of the single 24-bit CPU
//   address register. Serves the CPU core and DMA/HDMA channel engines. Each channel can increment,
//   decrement or hold, with linear, page-wrap or bank-wrap boundaries. Byte-lane writes with bank carry-in.
//   Boundary-crossing flags are registered for cycle-penalty and DMA sequencing logic.
// PARAMETERS
//   N_CH       8   number of address channels (>=1)
//   AW         24  address width in bits; multiple of 8
//   PAGE_BITS  8   width of page offset field [PAGE_BITS-1:0]; 1..BANK_BITS
//   BANK_BITS  16  width of in-bank offset [BANK_BITS-1:0]; multiple of 8, < AW; bank field = [AW-1:BANK_BITS]
// PORTS
//   clk       in   1          system clock
//   reset_n   in   1          synchronous reset, active low
//   cpu_en    in   1          clock enable; all state holds when 0
//   sel       in   CW         channel select, CW = max(1,$clog2(N_CH)); sel >= N_CH -> no write/step, rdata = 0
//   rdata     out  AW         combinational read of register[sel]
//   wdata     in   AW         write data
//   write     in   AW/8       byte-lane write enables for register[sel]
//   bank_inc  in   1          add 1 to bank field of register[sel] (write path only)
//   step      in   1          perform one address step on register[sel]
//   mode      in   2          00 inc, 01 dec, 10/11 hold
//   wrap      in   2          00 linear (mod 2^AW), 01 page wrap, 10 bank wrap, 11 = linear
//   page_cross out 1          registered: last step carried/borrowed out of the page field
//   bank_cross out 1          registered: last step carried/borrowed out of the in-bank field
// BEHAVIOUR
//   Reset (reset_n=0 at clk edge; overrides cpu_en): all registers = 0, page_cross = bank_cross = 0.
//   cpu_en=0: registers and flags hold. Only register[sel] is updated in any cycle; the others hold.
//   Step path (cpu_en & step): write and bank_inc are ignored in this cycle.
//     inc/dec, linear: r <= r +/- 1 mod 2^AW.
//     page wrap: only [PAGE_BITS-1:0] changes, mod 2^PAGE_BITS; upper bits hold.
//     bank wrap: only [BANK_BITS-1:0] changes, mod 2^BANK_BITS; bank field holds.
//     page_cross <= 1 iff the step carries out of (inc, low field all ones) or borrows from
//       (dec, low field zero) the page field. This holds in every wrap mode.
//     bank_cross <= same, using the [BANK_BITS-1:0] field.
//     hold mode: r unchanged, both flags <= 0.
//   Write path (cpu_en & ~step):
//     Non-bank lanes with write[i]=1 take wdata lane i.
//     Bank field: if any bank lane is written, bank <= wdata bank field + bank_inc. Otherwise bank <= bank + bank_inc.
//     Bank arithmetic is modulo 2^(AW-BANK_BITS).
//     Both flags <= 0 on any cpu_en cycle without step, whether or not anything is written.
//   Flags describe only the most recent enabled cycle; they are not per-channel.
//   Read: rdata reflects register[sel] before the edge; there is no bypass of same-cycle writes.
//   Latency: an update is visible on rdata the cycle after the enabled edge.
// TESTING
//   1 reset: load ch3=0xABCDEF, then reset_n=0 for 1 cycle -> all channels 0, flags 0, even with cpu_en=0.
//   2 linear inc ch0=0x12FFFF -> 0x130000, page_cross=1, bank_cross=1. Next idle cycle -> both flags 0.
//   3 page wrap inc ch1=0x7E12FF -> 0x7E1200, page_cross=1. Bank wrap dec ch2=0x7E0000 -> 0x7EFFFF, bank_cross=1.
//   4 ch4=0x01ABCD, write=3'b001, wdata=0xFFFF55, bank_inc=1 -> 0x02AB55.
//     Then write=3'b100, wdata=0xFF0000, bank_inc=1 -> 0x00AB55 (bank wraps).
//   5 step=1 with write=3'b111 on ch5=0x000010, inc linear -> 0x000011; write ignored; other channels unchanged.
//   6 cpu_en=0 with step/write/bank_inc asserted -> no change. sel=N_CH (when N_CH<2^CW) -> rdata=0, no state change.

Source files
------------

// File: rtl/addr_reg_bank.sv
// Bank of independently stepped/written address registers serving the CPU and DMA engines.
// One channel (sel) is read combinationally and updated per enabled cycle.
module addr_reg_bank #(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned AW        = 24,
  parameter int unsigned PAGE_BITS = 8,
  parameter int unsigned BANK_BITS = 16,
  localparam int unsigned CW       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned NL       = AW / 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_en,
  input  logic [CW-1:0] sel,
  output logic [AW-1:0] rdata,
  input  logic [AW-1:0] wdata,
  input  logic [NL-1:0] write,
  input  logic          bank_inc,
  input  logic          step,
  input  logic [1:0]    mode,
  input  logic [1:0]    wrap,
  output logic          page_cross,
  output logic          bank_cross
);

  localparam int unsigned BW = AW - BANK_BITS;
  localparam int unsigned BL = BANK_BITS / 8;
  localparam logic [AW-1:0] PageMask = {{(AW - PAGE_BITS){1'b0}}, {PAGE_BITS{1'b1}}};
  localparam logic [AW-1:0] BankMask = {{(AW - BANK_BITS){1'b0}}, {BANK_BITS{1'b1}}};

  logic [AW-1:0] regs_q [N_CH];
  logic [AW-1:0] regs_d [N_CH];
  logic          page_cross_q, page_cross_d;
  logic          bank_cross_q, bank_cross_d;

  logic          sel_valid;
  logic [AW-1:0] cur;
  logic [AW-1:0] step_sum;
  logic [AW-1:0] step_mask;
  logic [AW-1:0] step_val;
  logic [AW-1:0] wr_val;
  logic [BW-1:0] bank_base;
  logic          bank_wr;

  if (N_CH == (2 ** CW)) begin : g_full
    assign sel_valid = 1'b1;
  end else begin : g_partial
    assign sel_valid = ({{(32 - CW){1'b0}}, sel} < N_CH);
  end

  assign cur   = sel_valid ? regs_q[sel] : '0;
  assign rdata = cur;

  // Adding all-ones decrements; the mask confines the change to the wrap field.
  always_comb begin
    step_sum = cur + (mode[0] ? {AW{1'b1}} : {{(AW - 1){1'b0}}, 1'b1});
    unique case (wrap)
      2'b01:   step_mask = PageMask;
      2'b10:   step_mask = BankMask;
      default: step_mask = {AW{1'b1}};
    endcase
    step_val = (cur & ~step_mask) | (step_sum & step_mask);
  end

  always_comb begin
    wr_val = cur;
    for (int i = 0; i < BL; i++) begin
      if (write[i]) wr_val[8*i +: 8] = wdata[8*i +: 8];
    end
    bank_wr   = |write[NL-1:BL];
    bank_base = bank_wr ? wdata[AW-1:BANK_BITS] : cur[AW-1:BANK_BITS];
    wr_val[AW-1:BANK_BITS] = bank_base + {{(BW - 1){1'b0}}, bank_inc};
  end

  always_comb begin
    regs_d       = regs_q;
    page_cross_d = 1'b0;
    bank_cross_d = 1'b0;
    if (cpu_en && sel_valid) begin
      if (step) begin
        if (!mode[1]) begin
          regs_d[sel]  = step_val;
          page_cross_d = mode[0] ? ~|cur[PAGE_BITS-1:0] : &cur[PAGE_BITS-1:0];
          bank_cross_d = mode[0] ? ~|cur[BANK_BITS-1:0] : &cur[BANK_BITS-1:0];
        end
      end else begin
        regs_d[sel] = wr_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) regs_q[i] <= '0;
      page_cross_q <= 1'b0;
      bank_cross_q <= 1'b0;
    end else if (cpu_en) begin
      for (int i = 0; i < N_CH; i++) regs_q[i] <= regs_d[i];
      page_cross_q <= page_cross_d;
      bank_cross_q <= bank_cross_d;
    end
  end

  assign page_cross = page_cross_q;
  assign bank_cross = bank_cross_q;

endmodule
